serial_mag_comparator: RTL and testbench

//  Compares two WIDTH-bit unsigned operands serially, MSB-first, one 2-bit slice per clock.

---
 rtl/serial_mag_comparator.sv | 148 ++++++++++++++
 tb/tb_serial_mag_comparator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// Serial MSB-first magnitude comparator: one 2-bit slice per clock, valid/ready on both sides.
// Optional macro SERCMP_EARLY_EXIT_EN: when defined, COMPARE exits on the first unequal slice.
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             busy
);
    localparam int SLICES = WIDTH / 2;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               gt_reg, gt_next;
    logic               eq_reg, eq_next;
    logic               lt_reg, lt_next;
`ifndef SERCMP_EARLY_EXIT_EN
    logic               decided_reg, decided_next;
`endif

    logic [1:0]         slice_a, slice_b;
    logic [2:0]         slice_res;

    // 2-bit compare of A=a:b against B=c:d, returned as {gt, eq, lt}
    function automatic logic [2:0] cmp2(input logic [1:0] x, input logic [1:0] y);
        logic g, e, l;
        g = (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
        e = ~(x[1] ^ y[1]) & ~(x[0] ^ y[0]);
        l = ~g & ~e;
        return {g, e, l};
    endfunction

    assign slice_a   = a_reg[{idx_reg, 1'b0} +: 2];
    assign slice_b   = b_reg[{idx_reg, 1'b0} +: 2];
    assign slice_res = cmp2(slice_a, slice_b);

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        idx_next   = idx_reg;
        gt_next    = gt_reg;
        eq_next    = eq_reg;
        lt_next    = lt_reg;
`ifndef SERCMP_EARLY_EXIT_EN
        decided_next = decided_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = a_in;
                    b_next     = b_in;
                    idx_next   = IDX_W'(SLICES - 1);
                    gt_next    = 1'b0;
                    eq_next    = 1'b0;
                    lt_next    = 1'b0;
`ifndef SERCMP_EARLY_EXIT_EN
                    decided_next = 1'b0;
`endif
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
`ifdef SERCMP_EARLY_EXIT_EN
                if (slice_res[2]) begin
                    gt_next    = 1'b1;
                    state_next = DONE;
                end else if (slice_res[0]) begin
                    lt_next    = 1'b1;
                    state_next = DONE;
                end else if (idx_reg == '0) begin
                    eq_next    = 1'b1;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg - IDX_W'(1);
                end
`else
                // The MSB-most unequal slice wins; later slices cannot override it.
                if (!decided_reg && !slice_res[1]) begin
                    decided_next = 1'b1;
                    gt_next      = slice_res[2];
                    lt_next      = slice_res[0];
                end
                if (idx_reg == '0) begin
                    eq_next    = ~decided_reg & slice_res[1];
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg - IDX_W'(1);
                end
`endif
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            gt_reg    <= 1'b0;
            eq_reg    <= 1'b0;
            lt_reg    <= 1'b0;
`ifndef SERCMP_EARLY_EXIT_EN
            decided_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            idx_reg   <= idx_next;
            gt_reg    <= gt_next;
            eq_reg    <= eq_next;
            lt_reg    <= lt_next;
`ifndef SERCMP_EARLY_EXIT_EN
            decided_reg <= decided_next;
`endif
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == COMPARE);
    assign res_valid = (state_reg == DONE);
    assign gt        = gt_reg;
    assign eq        = eq_reg;
    assign lt        = lt_reg;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator (WIDTH=8); expectations follow SERCMP_EARLY_EXIT_EN.
module tb_serial_mag_comparator;
    localparam int W = 8;
    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in, b_in;
    logic         res_valid;
    logic         res_ready;
    logic         gt, eq, lt;
    logic         busy;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .gt(gt), .eq(eq), .lt(lt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] gel;
        int         lat;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    int   accept_cycle = 0;
    bit   reported = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Edges from the accept edge (inclusive) to the first res_valid cycle
    function automatic int lat_of(input int k);
`ifdef SERCMP_EARLY_EXIT_EN
        return k + 1;
`else
        return W / 2 + 1;
`endif
    endfunction

    // Handshake tracking happens on the active edge, before state updates settle
    always @(posedge clk) begin
        cycle++;
        if (rst_n && in_valid && in_ready) accept_cycle = cycle;
        if (rst_n && res_valid && res_ready) begin
            if (q.size() > 0) begin
                $display("txn done: gt=%0b eq=%0b lt=%0b expected gel=%03b", gt, eq, lt, q[0].gel);
                void'(q.pop_front());
            end
            reported = 0;
        end
    end

    // Monitor compares whenever a result is presented
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'(res_valid), 32'd0);
            end else begin
                chk("result_flags", {29'd0, gt, eq, lt}, {29'd0, q[0].gel});
                if (!reported) begin
                    chk("latency", 32'(cycle - accept_cycle + 1), 32'(q[0].lat));
                    reported = 1;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] gel, input int k, input bit push);
        int n;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        if (push) q.push_back('{gel: gel, lat: lat_of(k)});
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in     = ~a;
        b_in     = ~b;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_flags", {29'd0, gt, eq, lt}, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        @(negedge clk);
        send(8'hA5, 8'hA5, EQ, 4, 1);
        wait_idle();
        send(8'h80, 8'h7F, GT, 1, 1);
        wait_idle();
        send(8'h12, 8'h13, LT, 4, 1);
        wait_idle();
        send(8'h9C, 8'h98, GT, 3, 1);
        wait_idle();
        send(8'hFF, 8'hFE, GT, 4, 1);
        wait_idle();
        send(8'h3C, 8'h7C, LT, 1, 1);
        wait_idle();
        send(8'h00, 8'h00, EQ, 4, 1);
        wait_idle();

        // Consumer stalls: result must hold and no new operand accepted
        res_ready = 1'b0;
        send(8'h40, 8'h30, GT, 1, 1);
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("done_timeout", 32'(res_valid), 32'd1);
        repeat (6) begin
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_gt", 32'(gt), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_res_valid", 32'(res_valid), 32'd0);

        // Abort mid-COMPARE with a one-clock reset
        send(8'h01, 8'h00, GT, 4, 0);
        @(posedge clk);
        #1;
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_flags", {29'd0, gt, eq, lt}, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Second pair waits on in_valid while the first is still in progress
        send(8'h00, 8'hFF, LT, 1, 1);
        send(8'hFF, 8'h00, GT, 1, 1);
        wait_idle();

        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
